// File: rtl/fp8_pkg.sv
// ---------------------------------------------------------------------------
// fp8_pkg
// Shared definitions for the FP8 accumulation scheduler.
//   FP8 layout : {sign, exp[3:0], mant[2:0]}, bias 7, exp==0 means zero,
//                no subnormals, exp==15 is an ordinary finite value.
//   Contents   : field widths, bias, zero/saturation constants, the fp8_t
//                struct and the per-channel accumulate/pending state type.
// ---------------------------------------------------------------------------
package fp8_pkg;

  localparam int EXP_W    = 4;
  localparam int MAN_W    = 3;
  localparam int FP8_BIAS = 7;
  localparam int FP8_NCH  = 2;

  localparam logic [7:0]       FP8_ZERO    = 8'h00;
  localparam logic [EXP_W-1:0] FP8_SAT_EXP = 4'hF;
  localparam logic [MAN_W-1:0] FP8_SAT_MAN = 3'h7;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp8_t;

  // A channel either collects operands or holds a finished sum for output.
  typedef enum logic {
    CH_ACCUM = 1'b0,
    CH_PEND  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/fp8_add_core.sv
// ---------------------------------------------------------------------------
// fp8_add_core
// Purely combinational FP8 adder.
//   a, b : FP8 operands
//   sum  : a + b, smaller operand aligned by truncating right shift,
//          result normalised with truncation toward zero, underflow and
//          exact cancellation give +0, overflow saturates to {s,1111,111}.
//          A zero operand passes the other operand through untouched.
// ---------------------------------------------------------------------------
module fp8_add_core
  import fp8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  fp8_t             a_f, b_f, big_f, sml_f;
  logic             a_big;
  logic [EXP_W-1:0] exp_diff;
  logic [MAN_W:0]   big_sig, sml_sig;
  logic             eff_sub;
  logic [MAN_W+1:0] raw;
  logic [1:0]       lz;
  logic [MAN_W-1:0] norm_man;
  logic             ovf, unf;
  logic [EXP_W-1:0] exp_res;
  logic [MAN_W-1:0] man_res;

  assign a_f = fp8_t'(a);
  assign b_f = fp8_t'(b);

  // {exp,man} orders magnitudes directly for normal numbers.
  assign a_big = {a_f.exp, a_f.man} >= {b_f.exp, b_f.man};
  assign big_f = a_big ? a_f : b_f;
  assign sml_f = a_big ? b_f : a_f;

  assign exp_diff = big_f.exp - sml_f.exp;
  assign big_sig  = {1'b1, big_f.man};
  // Shifts of 4 or more flush the smaller significand to zero.
  assign sml_sig  = {1'b1, sml_f.man} >> exp_diff;
  assign eff_sub  = big_f.sign ^ sml_f.sign;

  // Larger magnitude minus smaller never goes negative.
  assign raw = eff_sub ? ({1'b0, big_sig} - {1'b0, sml_sig})
                       : ({1'b0, big_sig} + {1'b0, sml_sig});

  // Leading-zero count of raw[3:0]; only consulted when raw is non-zero
  // and has no carry out.
  always_comb begin
    lz = 2'd0;
    if (!raw[MAN_W]) begin
      lz = 2'd1;
      if (!raw[MAN_W-1]) begin
        lz = 2'd2;
        if (!raw[MAN_W-2]) begin
          lz = 2'd3;
        end
      end
    end
  end

  assign norm_man = raw[MAN_W-1:0] << lz;
  assign ovf      = raw[MAN_W+1] & (big_f.exp == FP8_SAT_EXP);
  assign unf      = ~raw[MAN_W+1] & ({{(EXP_W-2){1'b0}}, lz} >= big_f.exp);
  assign exp_res  = raw[MAN_W+1] ? (big_f.exp + 4'd1)
                                 : (big_f.exp - {{(EXP_W-2){1'b0}}, lz});
  // Carry case drops raw[0]: that is the truncating normalise.
  assign man_res  = raw[MAN_W+1] ? raw[MAN_W:1] : norm_man;

  always_comb begin
    sum = {big_f.sign, exp_res, man_res};
    if (a_f.exp == '0) begin
      sum = b;
    end else if (b_f.exp == '0) begin
      sum = a;
    end else if (raw == '0) begin
      sum = FP8_ZERO;
    end else if (ovf) begin
      sum = {big_f.sign, FP8_SAT_EXP, FP8_SAT_MAN};
    end else if (unf) begin
      sum = FP8_ZERO;
    end
  end

endmodule

// File: rtl/fp8_accum_sched.sv
// ---------------------------------------------------------------------------
// fp8_accum_sched
// Two-channel FP8 burst accumulator sharing one fp8_add_core.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_last    : per-channel operand valid / final beat of burst
//   in_data0, in_data1  : per-channel FP8 operand
//   in_ready            : per-channel accept, at most one bit high (grant)
//   out_valid/out_ready : finished-sum handshake
//   out_data, out_ch    : finished sum and the channel it belongs to
// One operand per cycle is granted round-robin; a channel that has seen its
// last beat freezes until its sum is taken from the shared result port.
// ---------------------------------------------------------------------------
module fp8_accum_sched
  import fp8_pkg::*;
#(
  parameter int NCH = FP8_NCH
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  logic [7:0]     in_data0,
  input  logic [7:0]     in_data1,
  input  logic [NCH-1:0] in_last,
  output logic [NCH-1:0] in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_ch
);

  ch_state_t   st_q  [NCH];
  ch_state_t   st_d  [NCH];
  logic [7:0]  acc_q [NCH];
  logic [7:0]  acc_d [NCH];
  logic        rr_q, rr_d;
  logic        opri_q, opri_d;

  logic [7:0]     in_data [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] grant;
  logic           gsel;
  logic [7:0]     add_sum;
  logic           take;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign pend[gi] = (st_q[gi] == CH_PEND);
    assign elig[gi] = in_valid[gi] & ~pend[gi];
  end

  // rr names the favoured channel only when both want the adder.
  assign grant = (&elig) ? (rr_q ? 2'b10 : 2'b01) : elig;
  assign gsel  = grant[1];
  // Registers are already cleared by rst, but in_valid is not.
  assign in_ready = grant & {NCH{~rst}};

  fp8_add_core u_add (
    .a   (acc_q[gsel]),
    .b   (in_data[gsel]),
    .sum (add_sum)
  );

  assign out_valid = |pend;
  assign out_ch    = (&pend) ? opri_q : pend[1];
  assign out_data  = acc_q[out_ch];
  assign take      = out_valid & out_ready;

  // A pending channel is never granted, so grant and take never touch the
  // same channel in one cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      acc_d[i] = acc_q[i];
    end
    rr_d   = rr_q;
    opri_d = opri_q;
    if (|grant) begin
      acc_d[gsel] = add_sum;
      if (in_last[gsel]) begin
        st_d[gsel] = CH_PEND;
      end
      rr_d = ~gsel;
    end
    if (take) begin
      st_d[out_ch]  = CH_ACCUM;
      acc_d[out_ch] = FP8_ZERO;
      opri_d        = ~opri_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= CH_ACCUM;
        acc_q[i] <= FP8_ZERO;
      end
      rr_q   <= 1'b0;
      opri_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        acc_q[i] <= acc_d[i];
      end
      rr_q   <= rr_d;
      opri_q <= opri_d;
    end
  end

endmodule

// File: tb/tb_fp8_accum_sched.sv
// ---------------------------------------------------------------------------
// tb_fp8_accum_sched
// Self-checking bench for fp8_accum_sched: table-driven bursts, hand-written
// arbitration / hold / reset sequences and a randomized run, all compared
// against a reference built from arithmetic on FP8 significands.
// ---------------------------------------------------------------------------
module tb_fp8_accum_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [1:0] in_last;
  logic [1:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ch;

  int total = 0;
  int bad   = 0;

  // Reference state: running sums, finished-but-unread flags, priorities.
  logic [7:0] m_acc [2];
  logic [1:0] m_pend;
  logic       m_rr;
  logic       m_opri;

  typedef struct packed {
    logic            ch;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic [7:0]      exp;
  } vec_t;

  vec_t vt [9];

  always #5 clk = ~clk;

  fp8_accum_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // FP8 sum from real significands (8..15) and exponents.
  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int ea, eb, ma, mb, el, es, ml, ms, r, e;
    bit sl, ss;
    if (a[6:3] == 4'd0) return b;
    if (b[6:3] == 4'd0) return a;
    ea = int'(a[6:3]); ma = 8 + int'(a[2:0]);
    eb = int'(b[6:3]); mb = 8 + int'(b[2:0]);
    if ((ma << ea) >= (mb << eb)) begin
      el = ea; ml = ma; sl = a[7]; es = eb; ms = mb; ss = b[7];
    end else begin
      el = eb; ml = mb; sl = b[7]; es = ea; ms = ma; ss = a[7];
    end
    ms = ms >> (el - es);
    r  = (sl == ss) ? (ml + ms) : (ml - ms);
    if (r == 0) return 8'h00;
    e = el;
    while (r >= 16) begin r = r / 2; e++; end
    while (r < 8)   begin r = r * 2; e--; end
    if (e > 15) return {sl, 7'h7F};
    if (e < 1)  return 8'h00;
    return {sl, e[3:0], r[2:0]};
  endfunction

  task automatic model_reset();
    m_acc[0] = 8'h00;
    m_acc[1] = 8'h00;
    m_pend   = 2'b00;
    m_rr     = 1'b0;
    m_opri   = 1'b0;
  endtask

  // Entered at posedge+1 with inputs driven; checks at negedge, advances the
  // reference at the posedge and returns at posedge+1.
  task automatic cycle();
    logic [1:0] elig, eg;
    logic       eov, eoch, g;
    logic [7:0] din [2];
    @(negedge clk);
    din[0] = in_data0;
    din[1] = in_data1;
    elig   = in_valid & ~m_pend;
    eg     = (elig == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : elig;
    eov    = |m_pend;
    eoch   = (&m_pend) ? m_opri : m_pend[1];
    check("in_ready", 32'(in_ready), 32'(eg));
    check("out_valid", 32'(out_valid), 32'(eov));
    if (eov) begin
      check("out_ch", 32'(out_ch), 32'(eoch));
      check("out_data", 32'(out_data), 32'(m_acc[eoch]));
    end
    @(posedge clk);
    if (eov && out_ready) begin
      m_pend[eoch] = 1'b0;
      m_acc[eoch]  = 8'h00;
      m_opri       = ~m_opri;
    end
    if (eg != 2'b00) begin
      g        = eg[1];
      m_acc[g] = ref_add(m_acc[g], din[g]);
      if (in_last[g]) m_pend[g] = 1'b1;
      m_rr = ~g;
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    in_valid  = 2'b00;
    in_last   = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 6 && m_pend != 2'b00; i++) cycle();
    out_ready = 1'b0;
    #1;
    check("drained_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] cnt0, cnt1;

    vt[0] = '{1'b0, 3'd2, {8'h00, 8'h00, 8'h38, 8'h38}, 8'h40};
    vt[1] = '{1'b1, 3'd2, {8'h00, 8'h00, 8'hB8, 8'h38}, 8'h00};
    vt[2] = '{1'b1, 3'd2, {8'h00, 8'h00, 8'h20, 8'h38}, 8'h39};
    vt[3] = '{1'b0, 3'd2, {8'h00, 8'h00, 8'h7F, 8'h7F}, 8'h7F};
    vt[4] = '{1'b0, 3'd1, {8'h00, 8'h00, 8'h00, 8'hC5}, 8'hC5};
    vt[5] = '{1'b1, 3'd2, {8'h00, 8'h00, 8'h88, 8'h09}, 8'h00};
    vt[6] = '{1'b0, 3'd3, {8'h00, 8'h05, 8'hB8, 8'h40}, 8'h38};
    vt[7] = '{1'b1, 3'd2, {8'h00, 8'h00, 8'hB8, 8'hF8}, 8'hF8};
    vt[8] = '{1'b1, 3'd2, {8'h00, 8'h00, 8'h31, 8'h39}, 8'h3D};

    // Reset state while producers are already asserting valid.
    rst       = 1'b1;
    in_valid  = 2'b11;
    in_last   = 2'b00;
    in_data0  = 8'h38;
    in_data1  = 8'h38;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 2'b00;
    model_reset();
    cycle();

    // Table-driven single-channel bursts.
    for (int v = 0; v < 9; v++) begin
      for (int j = 0; j < int'(vt[v].n); j++) begin
        in_valid = vt[v].ch ? 2'b10 : 2'b01;
        in_last  = (j == int'(vt[v].n) - 1) ? in_valid : 2'b00;
        if (vt[v].ch) in_data1 = vt[v].d[j];
        else          in_data0 = vt[v].d[j];
        cycle();
      end
      in_valid = 2'b00;
      in_last  = 2'b00;
      #1;
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_ch", 32'(out_ch), 32'(vt[v].ch));
      check("vec_out_data", 32'(out_data), 32'(vt[v].exp));
      $display("vec %0d ch=%0d n=%0d out=%02h req=%02h", v, vt[v].ch, vt[v].n, out_data, vt[v].exp);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end

    // Both channels streaming 4-beat bursts: strict alternation from ch0.
    do_reset();
    cnt0 = 3'd0;
    cnt1 = 3'd0;
    for (int k = 0; k < 8; k++) begin
      in_valid = {cnt1 < 3'd4, cnt0 < 3'd4};
      in_data0 = 8'h38;
      in_data1 = 8'h20;
      in_last  = {cnt1 == 3'd3, cnt0 == 3'd3};
      #1;
      check("stream_in_ready", 32'(in_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      cycle();
      if (k % 2 == 0) cnt0++;
      else            cnt1++;
    end
    in_valid = 2'b00;
    in_last  = 2'b00;
    for (int h = 0; h < 3; h++) begin
      #1;
      check("hold0_valid", 32'(out_valid), 32'd1);
      check("hold0_ch", 32'(out_ch), 32'd0);
      check("hold0_data", 32'(out_data), 32'h48);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      check("hold1_valid", 32'(out_valid), 32'd1);
      check("hold1_ch", 32'(out_ch), 32'd1);
      check("hold1_data", 32'(out_data), 32'h30);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Ch0 pending with valid held: ch1 owns the adder until handshake+1.
    in_valid = 2'b01;
    in_data0 = 8'h38;
    in_last  = 2'b01;
    cycle();
    in_valid = 2'b11;
    in_data1 = 8'h20;
    in_last  = 2'b01;
    for (int h = 0; h < 4; h++) begin
      #1;
      check("pend_hold_rdy", 32'(in_ready), 32'd2);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("handshake_rdy", 32'(in_ready), 32'd2);
    cycle();
    out_ready = 1'b0;
    #1;
    check("after_hs_rdy", 32'(in_ready), 32'd1);
    cycle();
    in_last = 2'b11;
    #1;
    check("ch1_last_rdy", 32'(in_ready), 32'd2);
    cycle();
    drain();

    // Reset in the middle of a burst while ch1 has a result waiting.
    in_valid = 2'b10;
    in_data1 = 8'h38;
    in_last  = 2'b10;
    cycle();
    in_valid = 2'b01;
    in_data0 = 8'h38;
    in_last  = 2'b00;
    cycle();
    cycle();
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_valid = 2'b01;
    in_data0 = 8'h38;
    in_last  = 2'b01;
    cycle();
    in_valid = 2'b00;
    in_last  = 2'b00;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_ch", 32'(out_ch), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h38);
    drain();

    // Randomized traffic against the reference.
    do_reset();
    for (int r = 0; r < 400; r++) begin
      in_valid  = 2'($urandom_range(0, 3));
      in_data0  = 8'($urandom);
      in_data1  = 8'($urandom);
      in_last   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (out_valid && out_ready) begin
        $display("rand %0d take ch=%0d data=%02h", r, out_ch, out_data);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
